vga_scan_out: RTL and testbench

Raster timing generator and pixel output stage for the 640x480@60 VGA display. It produces the `DrawX`/`DrawY` scan coordinates that the game controller consumes, registers the returned 24-bit `color_data` onto the VGA pins, and generates sync, blanking and the per-frame pulse that advances game state. It runs on the 50 MHz system clock and uses an internal divide-by-2 pixel enable, so there is no second clock domain.

---
 rtl/vga_scan_out.sv | 114 +++++++++++
 tb/tb_vga_scan_out.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// 640x480@60 raster generator: divide-by-2 pixel enable, scan counters,
// one-pixel-delayed sync/blank/colour output registers and a per-frame tick.
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [23:0] color_data,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_clk,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic        pix_en;
    logic        advance;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [9:0]  hc_nxt;
    logic [9:0]  vc_nxt;
    logic        hs0;
    logic        vs0;
    logic        act0;
    logic        frame_start;
    logic        hs_q;
    logic        vs_q;
    logic        blank_q;
    logic [23:0] rgb_q;

    // pix_en rises on the edges that advance the raster, so VGA_CLK's rising
    // edge coincides with a new DrawX/DrawY.
    assign advance = !pix_en;

    always_comb begin
        hc_nxt = hc + 10'd1;
        vc_nxt = vc;
        if (hc == H_MAX) begin
            hc_nxt = 10'd0;
            vc_nxt = (vc == V_MAX) ? 10'd0 : vc + 10'd1;
        end
    end

    always_comb begin
        hs0  = !((hc >= H_SYNC_START) && (hc < H_SYNC_END));
        vs0  = !((vc >= V_SYNC_START) && (vc < V_SYNC_END));
        act0 = (hc < H_ACT_END) && (vc < V_ACT_END);
    end

    // Stepping onto the first pixel of the first vsync line is where vs0 falls.
    assign frame_start = (hc == H_MAX) && (vc_nxt == V_SYNC_START);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_en     <= 1'b0;
            hc         <= 10'd0;
            vc         <= 10'd0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b1;
            rgb_q      <= 24'd0;
            frame_tick <= 1'b0;
        end else begin
            pix_en     <= !pix_en;
            frame_tick <= 1'b0;
            if (advance) begin
                hc         <= hc_nxt;
                vc         <= vc_nxt;
                hs_q       <= hs0;
                vs_q       <= vs0;
                blank_q    <= act0;
                rgb_q      <= act0 ? color_data : 24'd0;
                frame_tick <= frame_start;
            end
        end
    end

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign VGA_CLK     = pix_en;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign frame_clk   = vs_q;
    assign VGA_BLANK_N = blank_q & !Reset;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: a full-size instance for line/pixel checks and a
// shrunken instance for frame-level timing, both against a positional model.
module tb_vga_scan_out;

    logic        clk;
    logic        rst0, rst1;
    logic [23:0] col0, col1;

    logic [9:0] dx0, dy0, dx1, dy1;
    logic       vclk0, hs0, vs0, bn0, fc0, ft0;
    logic       vclk1, hs1, vs1, bn1, fc1, ft1;
    logic [7:0] r0, g0, b0, r1, g1, b1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    vga_scan_out dut0 (
        .Clk(clk), .Reset(rst0), .color_data(col0),
        .DrawX(dx0), .DrawY(dy0), .VGA_CLK(vclk0), .VGA_HS(hs0), .VGA_VS(vs0),
        .VGA_BLANK_N(bn0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
        .frame_clk(fc0), .frame_tick(ft0)
    );

    vga_scan_out #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut1 (
        .Clk(clk), .Reset(rst1), .color_data(col1),
        .DrawX(dx1), .DrawY(dy1), .VGA_CLK(vclk1), .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK_N(bn1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .frame_clk(fc1), .frame_tick(ft1)
    );

    initial clk = 0;
    always #10 clk = ~clk;

    // Model state: edges since reset release, pixel advances, last captured colour.
    int          t0 = 0, t1 = 0;
    longint      a0 = 0, a1 = 0;
    logic [23:0] cap0 = 0, cap1 = 0;

    always @(posedge clk) begin
        if (rst0) begin
            t0 <= 0; a0 <= 0; cap0 <= 0;
        end else begin
            t0 <= t0 + 1;
            if (t0 % 2 == 0) begin
                a0   <= a0 + 1;
                cap0 <= col0;
            end
        end
        if (rst1) begin
            t1 <= 0; a1 <= 0; cap1 <= 0;
        end else begin
            t1 <= t1 + 1;
            if (t1 % 2 == 0) begin
                a1   <= a1 + 1;
                cap1 <= col1;
            end
        end
    end

    function automatic void model_out(
        input int k, input logic rst_now, input int t, input longint a,
        input logic [23:0] cap,
        output logic [9:0] ex, output logic [9:0] ey, output logic eclk,
        output logic ehs, output logic evs, output logic ebn, output logic eft,
        output logic [23:0] ergb);
        int ha, hf, hsy, hb, va, vf, vsy, vb, ht, vt, mx, my;
        longint fr, n, m;
        if (k == 0) begin
            ha = 640; hf = 16; hsy = 96; hb = 48; va = 480; vf = 10; vsy = 2; vb = 33;
        end else begin
            ha = 16; hf = 4; hsy = 6; hb = 4; va = 12; vf = 2; vsy = 2; vb = 3;
        end
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        fr = longint'(ht) * vt;
        n = a % fr;
        ex = 10'(n % ht);
        ey = 10'(n / ht);
        eclk = (t % 2 == 1);
        eft = (t % 2 == 1) && (n == longint'((va + vf) * ht));
        if (a == 0) begin
            ehs = 1; evs = 1; ebn = 1; ergb = 0;
        end else begin
            m = (a - 1) % fr;
            mx = int'(m % ht);
            my = int'(m / ht);
            ehs = !(mx >= ha + hf && mx < ha + hf + hsy);
            evs = !(my >= va + vf && my < va + vf + vsy);
            ebn = (mx < ha) && (my < va);
            ergb = ebn ? cap : 24'd0;
        end
        if (rst_now) ebn = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    logic [9:0]  ex, ey;
    logic        eclk, ehs, evs, ebn, eft;
    logic [23:0] ergb;
    int          hs_low0 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            model_out(0, rst0, t0, a0, cap0, ex, ey, eclk, ehs, evs, ebn, eft, ergb);
            chk("x0", 32'(dx0), 32'(ex));
            chk("y0", 32'(dy0), 32'(ey));
            chk("vclk0", 32'(vclk0), 32'(eclk));
            chk("hs0", 32'(hs0), 32'(ehs));
            chk("vs0", 32'(vs0), 32'(evs));
            chk("fclk0", 32'(fc0), 32'(evs));
            chk("blank0", 32'(bn0), 32'(ebn));
            chk("tick0", 32'(ft0), 32'(eft));
            chk("rgb0", 32'({r0, g0, b0}), 32'(ergb));
            model_out(1, rst1, t1, a1, cap1, ex, ey, eclk, ehs, evs, ebn, eft, ergb);
            chk("x1", 32'(dx1), 32'(ex));
            chk("y1", 32'(dy1), 32'(ey));
            chk("vclk1", 32'(vclk1), 32'(eclk));
            chk("hs1", 32'(hs1), 32'(ehs));
            chk("vs1", 32'(vs1), 32'(evs));
            chk("fclk1", 32'(fc1), 32'(evs));
            chk("blank1", 32'(bn1), 32'(ebn));
            chk("tick1", 32'(ft1), 32'(eft));
            chk("rgb1", 32'({r1, g1, b1}), 32'(ergb));
            if (!rst0 && dy0 == 10'd0 && hs0 == 1'b0) hs_low0++;
        end
    end

    // Colour source: random, except row 7 of the full-size instance, which
    // carries 12_34_56 at column 5 and zero elsewhere.
    initial begin
        col0 = 0;
        col1 = 24'hFFFFFF;
        forever begin
            @(negedge clk);
            #1;
            if ((a0 % 420000) / 800 == 7)
                col0 = ((a0 % 800) == 5) ? 24'h123456 : 24'h0;
            else
                col0 = 24'($urandom);
            col1 = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'($urandom);
        end
    end

    task automatic wait0(input int x, input int y);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dx0 == 10'(x) && dy0 == 10'(y)) && n < 30000);
        if (n >= 30000) chk("wait0_timeout", 32'(n), 32'(0));
    endtask

    task automatic wait1(input int x, input int y);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dx1 == 10'(x) && dy1 == 10'(y)) && n < 5000);
        if (n >= 5000) chk("wait1_timeout", 32'(n), 32'(0));
    endtask

    task automatic count_to_tick1(output int cnt, output int vs_low);
        cnt = 0;
        vs_low = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (!vs1) vs_low++;
        end while (!ft1 && cnt < 5000);
    endtask

    task automatic seq0();
        @(negedge clk);
        chk("rel_x_first", 32'(dx0), 32'd1);
        chk("rel_vclk_first", 32'(vclk0), 32'd1);
        @(negedge clk);
        chk("rel_x_hold", 32'(dx0), 32'd1);
        chk("rel_vclk_low", 32'(vclk0), 32'd0);
        @(negedge clk);
        chk("rel_x_next", 32'(dx0), 32'd2);
        wait0(656, 0);
        chk("hs_before_fall", 32'(hs0), 32'd1);
        wait0(657, 0);
        chk("hs_fall", 32'(hs0), 32'd0);
        wait0(799, 0);
        repeat (2) @(negedge clk);
        chk("wrap_x", 32'(dx0), 32'd0);
        chk("wrap_y", 32'(dy0), 32'd1);
        chk("hs_low_clks", 32'(hs_low0), 32'd192);
        wait0(5, 7);
        chk("pix_before_rgb", 32'({r0, g0, b0}), 32'd0);
        wait0(6, 7);
        chk("pix_r", 32'(r0), 32'h12);
        chk("pix_g", 32'(g0), 32'h34);
        chk("pix_b", 32'(b0), 32'h56);
        chk("pix_blank", 32'(bn0), 32'd1);
        @(negedge clk);
        chk("pix_r_hold", 32'(r0), 32'h12);
        @(negedge clk);
        chk("pix_after_rgb", 32'({r0, g0, b0}), 32'd0);
    endtask

    task automatic seq1();
        int cnt, vs_low;
        count_to_tick1(cnt, vs_low);
        chk("first_tick_at", 32'(cnt), 32'd839);
        @(negedge clk);
        chk("tick_width", 32'(ft1), 32'd0);
        count_to_tick1(cnt, vs_low);
        chk("frame_period", 32'(cnt + 1), 32'd1140);
        chk("vs_low_clks", 32'(vs_low), 32'd120);
        wait1(10, 5);
        #1 rst1 = 1;
        @(negedge clk);
        chk("mid_rst_x", 32'(dx1), 32'd0);
        chk("mid_rst_y", 32'(dy1), 32'd0);
        chk("mid_rst_hs", 32'(hs1), 32'd1);
        chk("mid_rst_vs", 32'(vs1), 32'd1);
        chk("mid_rst_rgb", 32'({r1, g1, b1}), 32'd0);
        chk("mid_rst_blank", 32'(bn1), 32'd0);
        #1 rst1 = 0;
        count_to_tick1(cnt, vs_low);
        chk("tick_after_rst", 32'(cnt), 32'd839);
    endtask

    initial begin
        rst0 = 1;
        rst1 = 1;
        @(posedge clk);
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(dx0), 32'd0);
        chk("rst_blank", 32'(bn0), 32'd0);
        chk("rst_hs", 32'(hs0), 32'd1);
        chk("rst_fclk", 32'(fc0), 32'd1);
        chk("rst_vclk", 32'(vclk0), 32'd0);
        #1;
        rst0 = 0;
        rst1 = 0;
        fork
            seq0();
            seq1();
        join
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
